// File: rtl/acq_code_search_pkg.sv
// Shared types and defaults for the code-phase search sequencer.
// Widths track the tracking channel's code_shift and i2q2 ports.
package acq_code_search_pkg;

  localparam int CS_WIDTH_DEF   = 16;
  localparam int I2Q2_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/acq_peak_tracker.sv
// Running maximum of dwell power and the code shift where it occurred.
// Strict compare so that ties keep the earliest shift.
module acq_peak_tracker #(
  parameter int CS_WIDTH   = 16,
  parameter int I2Q2_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [I2Q2_WIDTH-1:0] i_power,
  input  logic [CS_WIDTH-1:0]   i_shift,
  output logic [I2Q2_WIDTH-1:0] o_peak,
  output logic [CS_WIDTH-1:0]   o_shift
);

  logic [I2Q2_WIDTH-1:0] r_peak;
  logic [CS_WIDTH-1:0]   r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak  <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_peak  <= '0;
      r_shift <= '0;
    end else if (i_en && (i_power > r_peak)) begin
      r_peak  <= i_power;
      r_shift <= i_shift;
    end
  end

  assign o_peak  = r_peak;
  assign o_shift = r_shift;

endmodule

// File: rtl/acq_code_search.sv
// Steps a channel's code shift over a window, one dwell per step,
// and reports peak power, its shift and a threshold verdict.
module acq_code_search
  import acq_code_search_pkg::*;
#(
  parameter int CS_WIDTH   = CS_WIDTH_DEF,
  parameter int I2Q2_WIDTH = I2Q2_WIDTH_DEF,
  parameter int TIMEOUT    = 65535,
  parameter int TO_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CS_WIDTH-1:0]   cs_first,
  input  logic [CS_WIDTH-1:0]   cs_last,
  input  logic [CS_WIDTH-1:0]   cs_step,
  input  logic [I2Q2_WIDTH-1:0] threshold,
  output logic                  seek_en,
  output logic [CS_WIDTH-1:0]   seek_target,
  input  logic [CS_WIDTH-1:0]   code_shift,
  output logic                  chan_reset,
  output logic                  feed_start,
  input  logic                  i2q2_valid,
  input  logic [I2Q2_WIDTH-1:0] i2q2,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  timeout,
  output logic [CS_WIDTH-1:0]   peak_shift,
  output logic [I2Q2_WIDTH-1:0] peak_power
);

  state_t r_state;
  state_t w_next;

  logic [CS_WIDTH-1:0]   r_last;
  logic [CS_WIDTH-1:0]   r_step;
  logic [CS_WIDTH-1:0]   r_target;
  logic [I2Q2_WIDTH-1:0] r_thr;
  logic [TO_WIDTH-1:0]   r_to;
  logic                  r_seek_en;
  logic                  r_chan_reset;
  logic                  r_feed_start;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_found;
  logic                  r_timeout;

  logic                  w_start;
  logic                  w_peak_en;
  logic                  w_to_hit;
  logic                  w_to_ev;
  logic [CS_WIDTH:0]     w_sum;
  logic [I2Q2_WIDTH-1:0] w_peak;

  // One extra bit so a step past the top of the range never wraps.
  assign w_sum     = {1'b0, r_target} + {1'b0, r_step};
  assign w_to_hit  = (r_to == TO_WIDTH'(TIMEOUT - 1));
  assign w_start   = (r_state == S_IDLE) && start && !abort;
  assign w_peak_en = (r_state == S_WAIT) && i2q2_valid && !abort;

  always_comb begin
    w_next  = r_state;
    w_to_ev = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) w_next = S_SEEK;
        S_SEEK: begin
          if (code_shift == r_target) begin
            w_next = S_CLEAR;
          end else if (w_to_hit) begin
            w_next  = S_DONE;
            w_to_ev = 1'b1;
          end
        end
        S_CLEAR: w_next = S_FEED;
        S_FEED:  w_next = S_WAIT;
        S_WAIT: begin
          if (i2q2_valid) begin
            w_next = S_NEXT;
          end else if (w_to_hit) begin
            w_next  = S_DONE;
            w_to_ev = 1'b1;
          end
        end
        S_NEXT: begin
          if (w_sum > {1'b0, r_last}) w_next = S_DONE;
          else                        w_next = S_SEEK;
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_state      <= S_IDLE;
      r_last       <= '0;
      r_step       <= '0;
      r_target     <= '0;
      r_thr        <= '0;
      r_to         <= '0;
      r_seek_en    <= 1'b0;
      r_chan_reset <= 1'b0;
      r_feed_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_to <= '0;
      end else if (r_state == S_SEEK || r_state == S_WAIT) begin
        r_to <= r_to + 1'b1;
      end
      if (w_start) begin
        r_last    <= cs_last;
        r_step    <= cs_step;
        r_thr     <= threshold;
        r_target  <= cs_first;
        r_found   <= 1'b0;
        r_timeout <= 1'b0;
      end else if (r_state == S_NEXT && w_next == S_SEEK) begin
        r_target <= w_sum[CS_WIDTH-1:0];
      end
      if (w_to_ev) r_timeout <= 1'b1;
      if (w_next == S_DONE) r_found <= (w_peak > r_thr);
      // Pulse/level outputs are registered decodes of the next state.
      r_seek_en    <= (w_next == S_SEEK);
      r_chan_reset <= (w_next == S_CLEAR);
      r_feed_start <= (w_next == S_FEED);
      r_done       <= (w_next == S_DONE);
      r_busy       <= (w_next != S_IDLE) && (w_next != S_DONE);
    end
  end

  acq_peak_tracker #(
    .CS_WIDTH   (CS_WIDTH),
    .I2Q2_WIDTH (I2Q2_WIDTH)
  ) u_peak (
    .clk     (clk),
    .rst_n   (global_reset_n),
    .i_clear (w_start),
    .i_en    (w_peak_en),
    .i_power (i2q2),
    .i_shift (r_target),
    .o_peak  (w_peak),
    .o_shift (peak_shift)
  );

  assign seek_en     = r_seek_en;
  assign seek_target = r_target;
  assign chan_reset  = r_chan_reset;
  assign feed_start  = r_feed_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign found       = r_found;
  assign timeout     = r_timeout;
  assign peak_power  = w_peak;

endmodule

// File: tb/tb_acq_code_search.sv
// Bench for acq_code_search: behavioural channel responder plus
// a window/peak reference model computed from the search rules.
module tb_acq_code_search;

  logic        clk = 1'b0;
  logic        global_reset_n;
  logic        start, abort;
  logic [15:0] cs_first, cs_last, cs_step;
  logic [31:0] threshold;
  logic        seek_en;
  logic [15:0] seek_target;
  logic [15:0] code_shift;
  logic        chan_reset, feed_start;
  logic        i2q2_valid;
  logic [31:0] i2q2;
  logic        busy, done, found, timeout;
  logic [15:0] peak_shift;
  logic [31:0] peak_power;

  int checks = 0;
  int errors = 0;

  logic        ch_stuck = 1'b0;
  logic        ch_hold  = 1'b0;
  int          stray_req = 0;
  int          stray_ack = 0;
  int          feed_cnt = 0;
  int          done_cnt = 0;
  int          pend = 0;
  int          sdly = 0;
  logic [31:0] pend_pw;
  logic [31:0] pw_arr [256];
  logic [15:0] got_sh [256];
  logic [31:0] plan [256];

  always #5 clk = ~clk;

  acq_code_search #(
    .CS_WIDTH(16), .I2Q2_WIDTH(32), .TIMEOUT(100), .TO_WIDTH(16)
  ) dut (
    .clk(clk), .global_reset_n(global_reset_n),
    .start(start), .abort(abort),
    .cs_first(cs_first), .cs_last(cs_last), .cs_step(cs_step),
    .threshold(threshold),
    .seek_en(seek_en), .seek_target(seek_target),
    .code_shift(code_shift),
    .chan_reset(chan_reset), .feed_start(feed_start),
    .i2q2_valid(i2q2_valid), .i2q2(i2q2),
    .busy(busy), .done(done), .found(found), .timeout(timeout),
    .peak_shift(peak_shift), .peak_power(peak_power)
  );

  // Channel model: slews to the seek target after a random delay and
  // returns one power result a few cycles after each replay start.
  always @(negedge clk) begin
    i2q2_valid = 1'b0;
    if (ch_stuck) begin
      code_shift = 16'hDEAD;
    end else if (seek_en && code_shift != seek_target) begin
      if (sdly == 0) begin
        code_shift = seek_target;
        sdly = $urandom_range(0, 3);
      end else begin
        sdly--;
      end
    end
    if (feed_start) begin
      got_sh[feed_cnt % 256] = seek_target;
      pend_pw = pw_arr[feed_cnt % 256];
      feed_cnt++;
      pend = ch_hold ? 0 : $urandom_range(1, 4);
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i2q2_valid = 1'b1;
        i2q2 = pend_pw;
      end
    end
    if (stray_req != stray_ack) begin
      i2q2_valid = 1'b1;
      i2q2 = 32'hFFFF_FFFF;
      stray_ack++;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic run_search(input int f, input int l, input int st,
                            input logic [31:0] thr, input string nm);
    int sh[$];
    int s, n, base, bad;
    logic [31:0] pk;
    logic [15:0] ps;
    bit seen;
    s = f;
    forever begin
      sh.push_back(s);
      if (s + st > l) break;
      s = s + st;
    end
    n = sh.size();
    base = feed_cnt;
    pk = 0;
    ps = 0;
    for (int i = 0; i < n; i++) begin
      pw_arr[(base + i) % 256] = plan[i];
      if (plan[i] > pk) begin
        pk = plan[i];
        ps = sh[i][15:0];
      end
    end
    @(negedge clk);
    cs_first = f[15:0];
    cs_last = l[15:0];
    cs_step = st[15:0];
    threshold = thr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 5000; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done: no done within 5000 cycles", nm);
    end
    checks++;
    if (peak_power !== pk) begin
      errors++;
      $display("FAIL %s peak_power: got %0h exp %0h", nm, peak_power, pk);
    end
    checks++;
    if (peak_shift !== ps) begin
      errors++;
      $display("FAIL %s peak_shift: got %0h exp %0h", nm, peak_shift, ps);
    end
    checks++;
    if (found !== (pk > thr)) begin
      errors++;
      $display("FAIL %s found: got %0b exp %0b", nm, found, pk > thr);
    end
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s flags: timeout %0b busy %0b exp 0 0", nm, timeout, busy);
    end
    checks++;
    if (feed_cnt - base !== n) begin
      errors++;
      $display("FAIL %s dwells: got %0d exp %0d", nm, feed_cnt - base, n);
    end
    bad = 0;
    for (int i = 0; i < n; i++)
      if (got_sh[(base + i) % 256] !== sh[i][15:0]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s shifts: got %0d wrong exp 0", nm, bad);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    global_reset_n = 1'b0;
    start = 0; abort = 0;
    cs_first = 0; cs_last = 0; cs_step = 1; threshold = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({seek_en, chan_reset, feed_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset strobes: got %b exp 000", {seek_en, chan_reset, feed_start});
    end
    checks++;
    if ({busy, done, found, timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset status: got %b exp 0000", {busy, done, found, timeout});
    end
    checks++;
    if (seek_target !== 16'h0 || peak_shift !== 16'h0 || peak_power !== 32'h0) begin
      errors++;
      $display("FAIL reset values: tgt %0h ps %0h pp %0h exp 0", seek_target, peak_shift, peak_power);
    end
    global_reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    plan[0] = 10; plan[1] = 50; plan[2] = 30;
    run_search(0, 4, 2, 32'd40, "directed");
  endtask

  task automatic test_tie();
    plan[0] = 20; plan[1] = 20;
    run_search(0, 1, 1, 32'd25, "tie");
  endtask

  task automatic test_wrap();
    plan[0] = 32'h1234_5678;
    run_search(32'hFFF0, 32'hFFFF, 32'h8000, 32'h0, "wrap");
    plan[0] = 77;
    run_search(30, 10, 3, 32'd77, "inverted");
  endtask

  task automatic test_random();
    int f, l, st, n;
    logic [31:0] thr;
    for (int k = 0; k < 10; k++) begin
      f = $urandom_range(0, 60);
      st = $urandom_range(1, 9);
      if ($urandom_range(0, 4) == 0 && f > 0) l = f - $urandom_range(1, f);
      else l = f + $urandom_range(0, 40);
      n = 45;
      for (int i = 0; i < n; i++)
        plan[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      thr = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
      run_search(f, l, st, thr, "random");
    end
  endtask

  task automatic test_stray();
    plan[0] = 5; plan[1] = 60;
    run_search(3, 4, 1, 32'd100, "pre_stray");
    stray_req++;
    repeat (4) @(negedge clk);
    checks++;
    if (peak_power !== 32'd60 || peak_shift !== 16'd4) begin
      errors++;
      $display("FAIL stray: got %0h@%0h exp 3c@4", peak_power, peak_shift);
    end
  endtask

  task automatic test_timeout();
    int cnt, d0;
    bit seen;
    ch_stuck = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    cs_first = 16'h0100; cs_last = 16'h0200; cs_step = 1; threshold = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = seek_en ? 1 : 0;
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (seek_en) cnt++;
    end
    checks++;
    if (!seen || cnt != 100) begin
      errors++;
      $display("FAIL timeout_len: seen %0b seek cycles %0d exp 100", seen, cnt);
    end
    checks++;
    if (timeout !== 1'b1 || seek_en !== 1'b0 || found !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: to %0b seek %0b found %0b exp 1 0 0", timeout, seek_en, found);
    end
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: pulses %0d to %0b exp 1 1", done_cnt - d0, timeout);
    end
    ch_stuck = 1'b0;
  endtask

  task automatic test_abort();
    int d0;
    ch_hold = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    cs_first = 7; cs_last = 20; cs_step = 2; threshold = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (feed_start) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || seek_en !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy %0b seek %0b exp 0 0", busy, seek_en);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_nodone: pulses %0d exp 0", done_cnt - d0);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || seek_en !== 1'b0) begin
      errors++;
      $display("FAIL start_abort: busy %0b seek %0b exp 0 0", busy, seek_en);
    end
    ch_hold = 1'b0;
    plan[0] = 9; plan[1] = 3; plan[2] = 11;
    run_search(7, 11, 2, 32'd10, "after_abort");
  endtask

  task automatic test_reset_mid();
    ch_hold = 1'b1;
    @(negedge clk);
    cs_first = 2; cs_last = 9; cs_step = 1; threshold = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (feed_start) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    #2 global_reset_n = 1'b0;
    #1;
    checks++;
    if ({seek_en, chan_reset, feed_start, busy, done, found, timeout} !== 7'b0 ||
        seek_target !== 16'h0 || peak_power !== 32'h0 || peak_shift !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: bits %b tgt %0h pp %0h exp 0",
               {seek_en, chan_reset, feed_start, busy, done, found, timeout},
               seek_target, peak_power);
    end
    @(negedge clk);
    global_reset_n = 1'b1;
    ch_hold = 1'b0;
    @(negedge clk);
    plan[0] = 4; plan[1] = 8;
    run_search(1, 2, 1, 32'd8, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_tie();
    test_wrap();
    test_random();
    test_stray();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
